step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
Generates the single-cycle advance enable (step_enable) for the flow datapath from the board's step controls. Sources are a debounced manual key, a free-running divided rate, or every cycle. Sits between the KEY/SW wiring and the datapath clock-enable input. Mode changes come from a debounced switch_clock press, can be frozen by clock_lock, and are suppressed on CPU halt.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed before a key level is accepted (5 ms at 50 MHz).
RUN_BASE_LOG2, 16, log2 of the fastest RUN divisor.

Ports:
clock  input  1  system clock, CLOCK_50 domain
resetn  input  1  asynchronous active-low reset
user_clock  input  1  raw manual-step key, active-low (0 = pressed), asynchronous
switch_clock  input  1  raw mode-cycle key, active-high (1 = pressed), asynchronous
clock_lock  input  1  1 = mode changes ignored
rate  input  2  RUN speed select
halt  input  1  datapath halt request, level, synchronous
step_enable  output  1  one-cycle advance pulse
mode  output  2  00 STEP, 01 RUN, 10 FAST, 11 HALTED
step_count  output  16  number of step_enable pulses issued, wraps

Behaviour:
- Reset (async, resetn=0):
  - mode=STEP, step_enable=0, step_count=0.
  - Divider=0.
  - Synchronisers cleared to the released level: user_clock debounced=1, switch_clock debounced=0.
- Key conditioning, per key:
  - 2-FF synchroniser, then a debounce counter.
  - The debounced level takes the synchronised value only after DEBOUNCE_CYCLES consecutive cycles of disagreement. Any agreement clears the counter.
  - Press event: one-cycle pulse on the debounced transition to pressed (user 1->0, switch 0->1). Release produces nothing.
  - Press latency: step_enable rises exactly 2+DEBOUNCE_CYCLES+1 cycles after a clean raw edge.
- Mode FSM, evaluated each cycle in this priority order:
  1. halt=1: STEP/RUN/FAST -> HALTED; step_enable forced 0 in every mode.
  2. HALTED and halt=0 -> STEP.
  3. Switch press with clock_lock=0: STEP->RUN->FAST->STEP. Ignored in HALTED. With clock_lock=1 the press is discarded, not queued.
  4. Otherwise stay.
- step_enable generation (only when halt=0 and no mode change this cycle):
  - STEP: one pulse per user press event.
  - RUN: divisor N = 2^(RUN_BASE_LOG2 + 3*(3 - rate)), i.e. rate 11 fastest, rate 00 slowest. The divider counts 0..N-1 and pulses on the cycle it equals N-1, then wraps to 0.
  - FAST: step_enable=1 every cycle.
  - User presses in RUN/FAST are ignored.
- Divider clears to 0 on any mode change and on any change of rate. First RUN pulse occurs N cycles after entry, counting from 1 on the cycle after the mode register updates.
- Simultaneous switch and user press events in STEP: mode change wins, no step pulse.
- step_count increments on every cycle step_enable=1. 0xFFFF -> 0x0000.
- Reset mid-operation returns to the reset state immediately. Debounce counters restart, so a key held across reset must release and re-press to produce an event.
- All outputs are registered; step_enable is a flop output.

Test Plan (DEBOUNCE_CYCLES=4, RUN_BASE_LOG2=2):
- User press in STEP:
  - Clean drop held 10 cycles -> exactly one step_enable pulse, 7 cycles after the edge; step_count=1.
  - Glitch 0 for 3 cycles then 1 -> no pulse.
- Mode cycling:
  - Three switch presses -> mode 00->01->10->00.
  - Repeat with clock_lock=1 -> mode stays 00; releasing lock afterwards does not replay presses.
- RUN rates:
  - rate=11 -> pulses every 4 cycles; first pulse 4 cycles after mode=01.
  - Change rate to 10 mid-count -> divider clears; next pulse 32 cycles later.
- FAST and wrap:
  - FAST for 65536 cycles from step_count=0 -> step_count returns to 0x0000, step_enable high throughout.
- Halt:
  - In FAST assert halt -> next cycle mode=11, step_enable=0.
  - User/switch presses while halted -> no effect.
  - Deassert halt -> mode=00.
  - In STEP with halt=1, user press -> no pulse.
- Async reset:
  - resetn low for 1 cycle while in RUN with step_count=0x1234 -> immediately mode=00, step_count=0, step_enable=0.
  - No pulse while a key stays held after reset.

Source files
------------

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - step_enable source selection for the flow datapath
// Conditions the manual/mode keys and sequences STEP/RUN/FAST/HALTED.

module step_sequencer_key #(
    parameter int   CYCLES  = 4,
    parameter logic PRESSED = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_press
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic          w_ref;
    logic          w_diff;

    // Until a clean release has been seen, compare against the pressed level so
    // a key held through reset has to be released and pressed again.
    assign w_ref  = r_armed ? r_db : PRESSED;
    assign w_diff = (r_s2 != w_ref);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1    <= ~PRESSED;
            r_s2    <= ~PRESSED;
            r_db    <= ~PRESSED;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            o_press <= 1'b0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            o_press <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_db    <= r_s2;
                r_armed <= 1'b1;
                o_press <= r_armed && (r_s2 == PRESSED);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module step_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RUN_BASE_LOG2   = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        user_clock,
    input  logic        switch_clock,
    input  logic        clock_lock,
    input  logic [1:0]  rate,
    input  logic        halt,
    output logic        step_enable,
    output logic [1:0]  mode,
    output logic [15:0] step_count
);
    localparam logic [1:0] MODE_STEP   = 2'b00;
    localparam logic [1:0] MODE_RUN    = 2'b01;
    localparam logic [1:0] MODE_FAST   = 2'b10;
    localparam logic [1:0] MODE_HALTED = 2'b11;

    localparam int DIV_W = RUN_BASE_LOG2 + 9;
    localparam logic [DIV_W-1:0] DIV_ONES = '1;

    logic             w_user_press;
    logic             w_switch_press;
    logic [1:0]       w_next_mode;
    logic             w_mode_chg;
    logic             w_rate_chg;
    logic [DIV_W-1:0] w_div_max;
    logic             w_div_last;
    logic             w_fire;

    logic [1:0]       r_mode;
    logic [1:0]       r_rate;
    logic [DIV_W-1:0] r_div;
    logic             r_step_en;
    logic [15:0]      r_count;

    step_sequencer_key #(.CYCLES(DEBOUNCE_CYCLES), .PRESSED(1'b0)) u_user_key (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_raw   (user_clock),
        .o_press (w_user_press)
    );

    step_sequencer_key #(.CYCLES(DEBOUNCE_CYCLES), .PRESSED(1'b1)) u_switch_key (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_raw   (switch_clock),
        .o_press (w_switch_press)
    );

    always_comb begin
        w_next_mode = r_mode;
        if (halt) begin
            w_next_mode = MODE_HALTED;
        end else if (r_mode == MODE_HALTED) begin
            w_next_mode = MODE_STEP;
        end else if (w_switch_press && !clock_lock) begin
            case (r_mode)
                MODE_STEP: w_next_mode = MODE_RUN;
                MODE_RUN:  w_next_mode = MODE_FAST;
                default:   w_next_mode = MODE_STEP;
            endcase
        end
    end

    assign w_mode_chg = (w_next_mode != r_mode);
    assign w_rate_chg = (rate != r_rate);

    // Terminal count is N-1 where N = 2^(BASE + 3*(3-rate)).
    always_comb begin
        case (rate)
            2'd0:    w_div_max = DIV_ONES;
            2'd1:    w_div_max = DIV_ONES >> 3;
            2'd2:    w_div_max = DIV_ONES >> 6;
            default: w_div_max = DIV_ONES >> 9;
        endcase
    end

    assign w_div_last = (r_div == w_div_max);

    always_comb begin
        w_fire = 1'b0;
        if (!halt && !w_mode_chg) begin
            case (r_mode)
                MODE_STEP: w_fire = w_user_press;
                MODE_RUN:  w_fire = w_div_last && !w_rate_chg;
                MODE_FAST: w_fire = 1'b1;
                default:   w_fire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mode    <= MODE_STEP;
            r_rate    <= 2'b00;
            r_div     <= '0;
            r_step_en <= 1'b0;
            r_count   <= '0;
        end else begin
            r_mode <= w_next_mode;
            r_rate <= rate;
            if (w_mode_chg || w_rate_chg || w_div_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
            r_step_en <= w_fire;
            if (w_fire) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign step_enable = r_step_en;
    assign mode        = r_mode;
    assign step_count  = r_count;
endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - directed bench for step_sequencer with a window-based reference model

module tb_step_sequencer;
    localparam int D    = 4;
    localparam int BASE = 2;

    logic        clock = 1'b0;
    logic        resetn;
    logic        user_clock;
    logic        switch_clock;
    logic        clock_lock;
    logic [1:0]  rate;
    logic        halt;
    logic        step_enable;
    logic [1:0]  mode;
    logic [15:0] step_count;

    int vectors     = 0;
    int miscompares = 0;

    step_sequencer #(.DEBOUNCE_CYCLES(D), .RUN_BASE_LOG2(BASE)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .user_clock   (user_clock),
        .switch_clock (switch_clock),
        .clock_lock   (clock_lock),
        .rate         (rate),
        .halt         (halt),
        .step_enable  (step_enable),
        .mode         (mode),
        .step_count   (step_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw key samples per edge (2 = no valid sample since reset),
    // acceptance when the D samples that have passed the synchroniser all agree.
    logic [1:0]  hist [2][D+2];
    logic        m_db [2];
    logic        m_armed [2];
    logic        m_ev [2];
    logic        new_ev [2];
    logic        raw [2];
    logic        same;
    logic        v;
    logic        chg;
    logic [1:0]  m_mode;
    logic        m_en;
    logic [15:0] m_count;
    logic [1:0]  prev_rate;
    int          cyc = 0;
    int          last_clear = 0;
    int          n_div;
    int          elapsed;

    function automatic logic rel(input int k);
        return (k == 0);
    endfunction

    always @(posedge clock) begin
        if (!resetn) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < D + 2; j++) hist[k][j] = 2'd2;
                hist[k][0] = {1'b0, rel(k)};
                hist[k][1] = {1'b0, rel(k)};
                m_db[k]    = rel(k);
                m_armed[k] = 1'b0;
                m_ev[k]    = 1'b0;
            end
            m_mode     = 2'b00;
            m_en       = 1'b0;
            m_count    = 16'h0000;
            prev_rate  = 2'b00;
            last_clear = cyc;
        end else begin
            raw[0] = user_clock;
            raw[1] = switch_clock;
            for (int k = 0; k < 2; k++) begin
                for (int j = D + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = {1'b0, raw[k]};
                same = (hist[k][2] != 2'd2);
                for (int j = 3; j <= D + 1; j++) if (hist[k][j] != hist[k][2]) same = 1'b0;
                new_ev[k] = 1'b0;
                if (same) begin
                    v = hist[k][2][0];
                    if (!m_armed[k]) begin
                        if (v == rel(k)) m_armed[k] = 1'b1;
                    end else if (v != m_db[k]) begin
                        m_db[k]   = v;
                        new_ev[k] = (v != rel(k));
                    end
                end
            end
            chg = 1'b0;
            if (halt) begin
                if (m_mode != 2'b11) begin m_mode = 2'b11; chg = 1'b1; end
            end else if (m_mode == 2'b11) begin
                m_mode = 2'b00; chg = 1'b1;
            end else if (m_ev[1] && !clock_lock) begin
                m_mode = (m_mode == 2'b10) ? 2'b00 : m_mode + 2'b01;
                chg = 1'b1;
            end
            if (chg || rate != prev_rate) last_clear = cyc;
            prev_rate = rate;
            n_div   = 1 << (BASE + 3 * (3 - int'(rate)));
            elapsed = cyc - last_clear;
            m_en = 1'b0;
            if (!halt && !chg) begin
                case (m_mode)
                    2'b00:   m_en = m_ev[0];
                    2'b01:   m_en = (elapsed > 0) && (elapsed % n_div == 0);
                    2'b10:   m_en = 1'b1;
                    default: m_en = 1'b0;
                endcase
            end
            if (m_en) m_count = m_count + 16'd1;
            m_ev[0] = new_ev[0];
            m_ev[1] = new_ev[1];
        end
        cyc++;
        #1;
        chk("step_enable", 32'(step_enable), 32'(m_en));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("step_count", 32'(step_count), 32'(m_count));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int k, output int pulses);
        pulses = 0;
        if (k == 0) user_clock = 1'b0; else switch_clock = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (step_enable) pulses++;
            if (i == 8) begin user_clock = 1'b1; switch_clock = 1'b0; end
        end
    endtask

    int p, n, first, entry, np, zeros;
    int pulse_at [4];
    bit found;

    initial begin
        resetn = 1'b0; user_clock = 1'b1; switch_clock = 1'b0;
        clock_lock = 1'b0; rate = 2'b11; halt = 1'b0;
        tick(2);
        chk("reset_step_enable", 32'(step_enable), 32'd0);
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_count", 32'(step_count), 32'd0);
        resetn = 1'b1;
        tick(10);

        // clean manual press: pulse 2 + D + 1 = 7 edges after the drop
        user_clock = 1'b0; first = 0; n = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clock);
            if (step_enable) begin n++; if (first == 0) first = i; end
            if (i == 10) user_clock = 1'b1;
        end
        chk("press_latency", 32'(first), 32'd7);
        chk("press_pulses", 32'(n), 32'd1);
        chk("press_count", 32'(step_count), 32'd1);

        user_clock = 1'b0; n = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (step_enable) n++;
            if (i == 3) user_clock = 1'b1;
        end
        chk("glitch_pulses", 32'(n), 32'd0);

        rate = 2'b00;
        press(1, p); chk("cycle_run", 32'(mode), 32'd1);
        press(1, p); chk("cycle_fast", 32'(mode), 32'd2);
        press(1, p); chk("cycle_step", 32'(mode), 32'd0);
        clock_lock = 1'b1;
        for (int r = 0; r < 3; r++) begin
            press(1, p); chk("locked_mode", 32'(mode), 32'd0);
        end
        clock_lock = 1'b0;
        tick(10);
        chk("unlock_no_replay", 32'(mode), 32'd0);

        // RUN at rate 11: N = 4
        rate = 2'b11; tick(2);
        switch_clock = 1'b1; entry = 0; np = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (i == 8) switch_clock = 1'b0;
            if (mode == 2'b01 && entry == 0) entry = i;
            if (step_enable && np < 4) begin pulse_at[np] = i; np++; end
        end
        chk("run_entry", 32'(entry), 32'd7);
        chk("run_pulses", 32'(np), 32'd3);
        chk("run_first", 32'(pulse_at[0]), 32'd11);
        chk("run_period", 32'(pulse_at[1] - pulse_at[0]), 32'd4);

        // rate 10 mid-count: N = 32 from the clearing edge
        rate = 2'b10; first = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clock);
            if (step_enable && first == 0) first = j;
        end
        chk("rate_change_pulse", 32'(first), 32'd33);

        press(1, p);
        chk("to_fast", 32'(mode), 32'd2);
        halt = 1'b1;
        @(negedge clock);
        chk("halt_mode", 32'(mode), 32'd3);
        chk("halt_step_enable", 32'(step_enable), 32'd0);
        press(0, p); chk("halt_user_pulses", 32'(p), 32'd0);
        press(1, p); chk("halt_switch_pulses", 32'(p), 32'd0);
        chk("halt_mode_held", 32'(mode), 32'd3);
        halt = 1'b0;
        @(negedge clock);
        chk("unhalt_mode", 32'(mode), 32'd0);
        halt = 1'b1;
        press(0, p); chk("step_halt_pulses", 32'(p), 32'd0);
        halt = 1'b0;
        tick(2);

        // FAST wrap from a zero count
        resetn = 1'b0; @(negedge clock); resetn = 1'b1;
        tick(10);
        rate = 2'b00;
        press(1, p);
        switch_clock = 1'b1; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (mode == 2'b10) found = 1'b1;
        end
        chk("fast_entry", 32'(found), 32'd1);
        chk("fast_start_count", 32'(step_count), 32'd0);
        zeros = 0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clock);
            if (i == 8) switch_clock = 1'b0;
            if (!step_enable) zeros++;
        end
        chk("fast_low_cycles", 32'(zeros), 32'd0);
        chk("fast_wrap_count", 32'(step_count), 32'd0);

        // land in RUN with count 0x1234 (6 more FAST pulses before STEP)
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            if (m_count == 16'h122E) found = 1'b1; else @(negedge clock);
        end
        chk("count_target_reached", 32'(found), 32'd1);
        press(1, p);
        press(1, p);
        chk("pre_reset_mode", 32'(mode), 32'd1);
        chk("pre_reset_count", 32'(step_count), 32'h1234);
        user_clock = 1'b0;
        tick(2);
        resetn = 1'b0;
        #1;
        chk("async_mode", 32'(mode), 32'd0);
        chk("async_count", 32'(step_count), 32'd0);
        chk("async_step_enable", 32'(step_enable), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (step_enable) n++;
        end
        chk("held_key_pulses", 32'(n), 32'd0);
        user_clock = 1'b1;
        tick(12);
        press(0, p);
        chk("repress_pulses", 32'(p), 32'd1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
